// File: rtl/sprite_rom_arbiter.sv
// Two-port burst arbiter sharing the tetromino sprite ROM between playfield and preview renderers.
// Define SPRITE_ARB_RR_EN for round-robin arbitration; default build is fixed priority (port 0).
module sprite_rom_arbiter (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req0_i,
    input  logic [2:0]  type0_i,
    input  logic [9:0]  addr0_i,
    input  logic [3:0]  len0_i,
    input  logic        req1_i,
    input  logic [2:0]  type1_i,
    input  logic [9:0]  addr1_i,
    input  logic [3:0]  len1_i,
    output logic        gnt0_o,
    output logic        rvalid0_o,
    output logic        rlast0_o,
    output logic [23:0] rdata0_o,
    output logic        gnt1_o,
    output logic        rvalid1_o,
    output logic        rlast1_o,
    output logic [23:0] rdata1_o,
    output logic [9:0]  rom_addr_o,
    output logic [2:0]  rom_type_o,
    input  logic [23:0] rom_data_i
);

    typedef enum logic [1:0] {StIdle, StBurst0, StBurst1} state_e;

    state_e      state_q, state_d;
    logic [9:0]  rom_addr_q, rom_addr_d;
    logic [2:0]  rom_type_q, rom_type_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
    logic        tag_valid_q, tag_valid_d;
    logic        tag_port_q, tag_port_d;
    logic        tag_last_q, tag_last_d;
    logic        issuing, arb_point, vreq0, vreq1, pick1;
`ifdef SPRITE_ARB_RR_EN
    logic        last_q, last_d;
`endif

    always_comb begin
        issuing   = (state_q != StIdle);
        // cnt_q counts words still to issue after the current one
        arb_point = !issuing || (cnt_q == 4'd0);
        vreq0     = req0_i && !gnt0_q;
        vreq1     = req1_i && !gnt1_q;
`ifdef SPRITE_ARB_RR_EN
        pick1     = vreq1 && (!vreq0 || !last_q);
`else
        pick1     = vreq1 && !vreq0;
`endif
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        rom_type_d  = rom_type_q;
        cnt_d       = cnt_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        tag_valid_d = issuing;
        tag_port_d  = (state_q == StBurst1);
        tag_last_d  = issuing && (cnt_q == 4'd0);
`ifdef SPRITE_ARB_RR_EN
        last_d      = last_q;
`endif
        if (arb_point) begin
            if (vreq0 || vreq1) begin
                state_d    = pick1 ? StBurst1 : StBurst0;
                rom_addr_d = pick1 ? addr1_i : addr0_i;
                rom_type_d = pick1 ? type1_i : type0_i;
                // len 0 wraps to 15 remaining, i.e. 16 words
                cnt_d      = (pick1 ? len1_i : len0_i) - 4'd1;
                gnt0_d     = !pick1;
                gnt1_d     = pick1;
`ifdef SPRITE_ARB_RR_EN
                last_d     = pick1;
`endif
            end else begin
                state_d = StIdle;
            end
        end else begin
            rom_addr_d = rom_addr_q + 10'd1;
            cnt_d      = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            rom_addr_q  <= 10'd0;
            rom_type_q  <= 3'd0;
            cnt_q       <= 4'd0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            tag_valid_q <= 1'b0;
            tag_port_q  <= 1'b0;
            tag_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            rom_type_q  <= rom_type_d;
            cnt_q       <= cnt_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            tag_valid_q <= tag_valid_d;
            tag_port_q  <= tag_port_d;
            tag_last_q  <= tag_last_d;
        end
    end

`ifdef SPRITE_ARB_RR_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign gnt0_o     = gnt0_q;
    assign gnt1_o     = gnt1_q;
    assign rvalid0_o  = tag_valid_q && !tag_port_q;
    assign rvalid1_o  = tag_valid_q && tag_port_q;
    assign rlast0_o   = rvalid0_o && tag_last_q;
    assign rlast1_o   = rvalid1_o && tag_last_q;
    assign rdata0_o   = rom_data_i;
    assign rdata1_o   = rom_data_i;
    assign rom_addr_o = rom_addr_q;
    assign rom_type_o = rom_type_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: vector table, directed corner sequences, random stress.
module tb_sprite_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [2:0]  type0, type1;
    logic [9:0]  addr0, addr1;
    logic [3:0]  len0, len1;
    logic        gnt0, rvalid0, rlast0, gnt1, rvalid1, rlast1;
    logic [23:0] rdata0, rdata1, rom_data;
    logic [9:0]  rom_addr;
    logic [2:0]  rom_type;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sprite_rom_arbiter dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .req0_i    (req0),
        .type0_i   (type0),
        .addr0_i   (addr0),
        .len0_i    (len0),
        .req1_i    (req1),
        .type1_i   (type1),
        .addr1_i   (addr1),
        .len1_i    (len1),
        .gnt0_o    (gnt0),
        .rvalid0_o (rvalid0),
        .rlast0_o  (rlast0),
        .rdata0_o  (rdata0),
        .gnt1_o    (gnt1),
        .rvalid1_o (rvalid1),
        .rlast1_o  (rlast1),
        .rdata1_o  (rdata1),
        .rom_addr_o(rom_addr),
        .rom_type_o(rom_type),
        .rom_data_i(rom_data)
    );

    function automatic logic [23:0] rom_word(input logic [2:0] t, input logic [9:0] a);
        return {8'hA5, 3'b000, t, a};
    endfunction

    // Registered ROM model
    always @(posedge clk) rom_data <= rom_word(rom_type, rom_addr);

    function automatic logic [18:0] pack(input logic g0, input logic g1, input logic v0,
                                         input logic l0, input logic v1, input logic l1,
                                         input logic [9:0] a, input logic [2:0] t);
        return {g0, g1, v0, l0, v1, l1, a, t};
    endfunction

    function automatic logic [18:0] obs();
        return {gnt0, gnt1, rvalid0, rlast0, rvalid1, rlast1, rom_addr, rom_type};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0 = 1'b0; req1 = 1'b0;
        type0 = 3'd0; addr0 = 10'd0; len0 = 4'd0;
        type1 = 3'd0; addr1 = 10'd0; len1 = 4'd0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("reset_state", 64'(obs()), 64'(19'd0));
    endtask

    typedef struct {
        logic        r0;
        logic [2:0]  t0;
        logic [9:0]  a0;
        logic [3:0]  l0;
        logic        r1;
        logic [2:0]  t1;
        logic [9:0]  a1;
        logic [3:0]  l1;
        logic [18:0] exp;
    } vec_t;

    typedef struct packed {
        logic        port;
        logic        last;
        logic [23:0] data;
    } word_t;

    vec_t  tbl[$];
    word_t sb[$];
    word_t w;
    logic [18:0] e, p;
    logic [9:0]  ea;
    logic [2:0]  et;
    int          port;
    logic        pend0, pend1;

    function automatic vec_t mk(input logic r0, input logic [2:0] t0, input logic [9:0] a0,
                                input logic [3:0] l0, input logic r1, input logic [2:0] t1,
                                input logic [9:0] a1, input logic [3:0] l1,
                                input logic [18:0] exp);
        vec_t v;
        v.r0 = r0; v.t0 = t0; v.a0 = a0; v.l0 = l0;
        v.r1 = r1; v.t1 = t1; v.a1 = a1; v.l1 = l1;
        v.exp = exp;
        return v;
    endfunction

    initial begin
        // Inputs and observed outputs for consecutive cycles after reset
        tbl.push_back(mk(1, 1, 10'h000, 4, 0, 0, 0, 0, pack(0, 0, 0, 0, 0, 0, 10'h000, 0)));
        tbl.push_back(mk(1, 1, 10'h000, 4, 0, 0, 0, 0, pack(1, 0, 0, 0, 0, 0, 10'h000, 1)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,        pack(0, 0, 1, 0, 0, 0, 10'h001, 1)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,        pack(0, 0, 1, 0, 0, 0, 10'h002, 1)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,        pack(0, 0, 1, 0, 0, 0, 10'h003, 1)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,        pack(0, 0, 1, 1, 0, 0, 10'h003, 1)));
        tbl.push_back(mk(0, 0, 0, 0, 1, 7, 10'h3FE, 3, pack(0, 0, 0, 0, 0, 0, 10'h003, 1)));
        tbl.push_back(mk(0, 0, 0, 0, 1, 7, 10'h3FE, 3, pack(0, 1, 0, 0, 0, 0, 10'h3FE, 7)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,        pack(0, 0, 0, 0, 1, 0, 10'h3FF, 7)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,        pack(0, 0, 0, 0, 1, 0, 10'h000, 7)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,        pack(0, 0, 0, 0, 1, 1, 10'h000, 7)));
        tbl.push_back(mk(1, 2, 10'h155, 1, 0, 0, 0, 0, pack(0, 0, 0, 0, 0, 0, 10'h000, 7)));
        tbl.push_back(mk(1, 2, 10'h155, 1, 0, 0, 0, 0, pack(1, 0, 0, 0, 0, 0, 10'h155, 2)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,        pack(0, 0, 1, 1, 0, 0, 10'h155, 2)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,        pack(0, 0, 0, 0, 0, 0, 10'h155, 2)));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 10'h07F, 2, pack(0, 0, 0, 0, 0, 0, 10'h155, 2)));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 10'h07F, 2, pack(0, 1, 0, 0, 0, 0, 10'h07F, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,        pack(0, 0, 0, 0, 1, 0, 10'h080, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,        pack(0, 0, 0, 0, 1, 1, 10'h080, 0)));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,        pack(0, 0, 0, 0, 0, 0, 10'h080, 0)));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            chk($sformatf("vec%0d", i), 64'(obs()), 64'(tbl[i].exp));
            e = tbl[i].exp;
            if (i > 0 && (e[16] || e[14])) begin
                p = tbl[i-1].exp;
                chk($sformatf("vec%0d_rdata", i), 64'({rdata0, rdata1}),
                    64'({rom_word(p[2:0], p[12:3]), rom_word(p[2:0], p[12:3])}));
            end
            req0 = tbl[i].r0; type0 = tbl[i].t0; addr0 = tbl[i].a0; len0 = tbl[i].l0;
            req1 = tbl[i].r1; type1 = tbl[i].t1; addr1 = tbl[i].a1; len1 = tbl[i].l1;
            step();
        end

        // Contention with both requests held, len 2 each
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c >= 1 && c <= 8) begin
`ifdef SPRITE_ARB_RR_EN
                port = ((c - 1) / 2) % 2;
`else
                port = 0;
`endif
                ea = ((port == 1) ? 10'h200 : 10'h100) + ((c % 2 == 1) ? 10'd0 : 10'd1);
                chk($sformatf("contend_c%0d", c), 64'({gnt0, gnt1, rom_addr}),
                    64'({(c % 2 == 1) && port == 0, (c % 2 == 1) && port == 1, ea}));
            end
            if (c == 0) begin
                req0 = 1'b1; type0 = 3'd1; addr0 = 10'h100; len0 = 4'd2;
                req1 = 1'b1; type1 = 3'd5; addr1 = 10'h200; len1 = 4'd2;
            end
            if (c == 8) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            step();
        end

        // 16-word burst on port 0 with req1 pending: no bubble before gnt1
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            if (c == 0) begin
                ea = 10'h000; et = 3'd0;
            end else if (c <= 16) begin
                ea = 10'h020 + 10'(c - 1); et = 3'd4;
            end else if (c == 17) begin
                ea = 10'h300; et = 3'd6;
            end else begin
                ea = 10'h301; et = 3'd6;
            end
            chk($sformatf("len16_c%0d", c), 64'(obs()),
                64'(pack(c == 1, c == 17, c >= 2 && c <= 17, c == 17, c == 18 || c == 19,
                         c == 19, ea, et)));
            if (c == 0) begin
                req0 = 1'b1; type0 = 3'd4; addr0 = 10'h020; len0 = 4'd0;
                req1 = 1'b1; type1 = 3'd6; addr1 = 10'h300; len1 = 4'd2;
            end
            if (c == 2) req0 = 1'b0;
            if (c == 18) req1 = 1'b0;
            step();
        end

        // Reset during word 2 of an 8-word burst, then a fresh request
        do_reset();
        for (int c = 0; c <= 16; c++) begin
            if (c == 1)       e = pack(1, 0, 0, 0, 0, 0, 10'h040, 2);
            else if (c == 2)  e = pack(0, 0, 1, 0, 0, 0, 10'h041, 2);
            else if (c == 3)  e = pack(0, 0, 1, 0, 0, 0, 10'h042, 2);
            else if (c == 14) e = pack(1, 0, 0, 0, 0, 0, 10'h050, 3);
            else if (c == 15) e = pack(0, 0, 1, 1, 0, 0, 10'h050, 3);
            else if (c == 16) e = pack(0, 0, 0, 0, 0, 0, 10'h050, 3);
            else              e = 19'd0;
            chk($sformatf("midreset_c%0d", c), 64'(obs()), 64'(e));
            if (c == 15) chk("midreset_rdata", 64'(rdata0), 64'(rom_word(3'd3, 10'h050)));
            if (c == 0) begin
                req0 = 1'b1; type0 = 3'd2; addr0 = 10'h040; len0 = 4'd8;
            end
            if (c == 2) req0 = 1'b0;
            if (c == 3) reset = 1'b1;
            if (c == 4) reset = 1'b0;
            if (c == 13) begin
                req0 = 1'b1; type0 = 3'd3; addr0 = 10'h050; len0 = 4'd1;
            end
            if (c == 15) req0 = 1'b0;
            step();
        end

        // Random stress against a scoreboard of granted bursts
        do_reset();
        pend0 = 1'b0; pend1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            chk("rvalid_exclusive", 64'(rvalid0 && rvalid1), 64'(0));
            if (gnt0) begin
                for (int i = 0; i < ((len0 == 4'd0) ? 16 : int'(len0)); i++) begin
                    w.port = 1'b0; w.last = (i == ((len0 == 4'd0) ? 15 : int'(len0) - 1));
                    w.data = rom_word(type0, addr0 + 10'(i));
                    sb.push_back(w);
                end
            end
            if (gnt1) begin
                for (int i = 0; i < ((len1 == 4'd0) ? 16 : int'(len1)); i++) begin
                    w.port = 1'b1; w.last = (i == ((len1 == 4'd0) ? 15 : int'(len1) - 1));
                    w.data = rom_word(type1, addr1 + 10'(i));
                    sb.push_back(w);
                end
            end
            if (rvalid0 || rvalid1) begin
                if (sb.size() == 0) begin
                    chk("stress_unexpected_rvalid", 64'(1), 64'(0));
                end else begin
                    w = sb.pop_front();
                    chk($sformatf("stress_word_c%0d", c),
                        64'({rvalid1, rvalid1 ? rlast1 : rlast0, rvalid1 ? rdata1 : rdata0}),
                        64'(w));
                end
            end
            if (gnt0) pend0 = 1'b0;
            else if (req0 && !pend0) req0 = 1'b0;
            else if (!req0 && c < 300 && $urandom_range(3) == 0) begin
                req0 = 1'b1; pend0 = 1'b1;
                type0 = 3'($urandom_range(7)); addr0 = 10'($urandom_range(1023));
                len0 = 4'($urandom_range(15));
            end
            if (gnt1) pend1 = 1'b0;
            else if (req1 && !pend1) req1 = 1'b0;
            else if (!req1 && c < 300 && $urandom_range(3) == 0) begin
                req1 = 1'b1; pend1 = 1'b1;
                type1 = 3'($urandom_range(7)); addr1 = 10'($urandom_range(1023));
                len1 = 4'($urandom_range(15));
            end
            step();
        end
        chk("stress_drained", 64'({sb.size() == 0, pend0, pend1}), 64'(3'b100));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Two-port burst arbiter that shares the single tetromino sprite ROM (16x16 tile, 24-bit RGB words, 1-cycle registered read, 3-bit piece type, 10-bit address) between the playfield pixel renderer (port 0) and the next-piece preview renderer (port 1). Each requester asks for a burst of up to 16 consecutive words of one piece type. The arbiter sequences the ROM address and type one word per cycle, and routes returned data back with valid/last qualifiers. It sits between both renderers and the ROM.

## Interface
- No parameters.
- Clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- reqN (N=0,1)  in  1  burst request; held until gntN
- typeN  in  3  piece type (1..7, 0 = white fill), stable while reqN high
- addrN  in  10  burst start address, stable while reqN high
- lenN  in  4  burst length; 1..15 literal, 0 means 16
- gntN  out  1  one-cycle pulse: burst accepted, first address on ROM this cycle
- rvalidN  out  1  rdataN holds a word of port N's burst
- rlastN  out  1  with rvalidN, final word of burst
- rdataN  out  24  mirrors rom_data; meaningful only when rvalidN high
- rom_addr  out  10  address to sprite ROM
- rom_type  out  3  piece type to sprite ROM
- rom_data  in  24  ROM registered output, valid the cycle after rom_addr/rom_type

## Operation
- States: IDLE, BURST0, BURST1.
- Arbitration points: any edge where the state is IDLE, and the edge ending the cycle that issues the final address of a burst.
- At an arbitration point, if any unmasked req is high, latch the winner's type, addr, and len. Enter BURSTk and pulse gntk in the following cycle. Otherwise enter or stay in IDLE.
- Mask: a port's req is ignored during the cycle its gnt is high. The requester drops req on the edge after gnt.
- In BURSTk, cycle i (0-based): rom_addr = (addr + i) mod 1024 with 10-bit wrap; rom_type = latched type. Stay for len cycles.
- Issue tag register (valid, port, last) is set on every issuing cycle. Next cycle it drives rvalid/rlast of the tagged port. rdata0 = rdata1 = rom_data.
- In IDLE: rom_addr and rom_type hold their last values; no tag is set.
- Reset values: state IDLE; gnt0/1 = 0; rvalid0/1 = 0; rlast0/1 = 0; rom_addr = 0; rom_type = 0; tag valid = 0; last-winner = port 1.
- Reset mid-burst: the burst is aborted and no further rvalid is produced, including for the word already issued. Requesters must re-request.
- The arbiter does not check type values; it passes them to the ROM unchanged.

## Timing
- req sampled high at edge E (state IDLE) -> gnt and first rom_addr in cycle E+1.
- First rvalid in cycle E+2; rlast in cycle E+1+len.
- Back-to-back: the next burst's gnt and first address appear in the cycle immediately after the previous burst's last address. There is no bubble on the ROM.
- Throughput: one ROM word per cycle while any request is pending.
- Simultaneous req0 and req1 at an arbitration point: resolved per Configuration. The loser keeps req high and is served at the next arbitration point.
- rvalid0 and rvalid1 are never high in the same cycle.

## Configuration
- SPRITE_ARB_RR_EN defined: round-robin. On contention the port that did not win the last arbitration wins. last-winner updates on every grant. After reset, port 0 wins the first contention.
- SPRITE_ARB_RR_EN undefined: fixed priority, port 0 always wins. The last-winner register is not built. Port 1 can starve by design; the renderer only reads the preview during blanking.

## Test plan
- Reset, then req0 with type=1, addr=0x000, len=4 at cycle 0 -> gnt0 in cycle 1; rom_addr 0,1,2,3 in cycles 1-4; rvalid0 in cycles 2-5; rlast0 in cycle 5; port 1 outputs stay 0.
- Wrap: req1 with type=7, addr=0x3FE, len=3 -> rom_addr 0x3FE, 0x3FF, 0x000; rom_type=7 throughout; rvalid1/rlast1 as above.
- Contention: req0 and req1 both high from cycle 0, each len=2 and held after gnt is handled -> fixed priority serves port 0 repeatedly. With SPRITE_ARB_RR_EN it alternates 0,1,0,1 with no idle ROM cycles.
- len=0 (16 words) on port 0 followed by a pending req1 -> 16 consecutive port-0 addresses, then gnt1 in the very next cycle.
- Assert Reset during word 2 of an 8-word burst -> all outputs 0 the next cycle; no rvalid for words 2 and up; a fresh req0 afterwards is granted normally.
- Random stress against a reference model comparing rdata with the ROM contents -> every rvalid matches, rvalid0 and rvalid1 are never both high, and each burst produces exactly one rlast.
